// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO shift-add multiplier.
package mult_hilo_unit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Iteration counter width; at least one bit so a 1-bit datapath still elaborates.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_hilo_unit.sv
// Iterative shift-add multiplier with HI/LO result registers (MULT/MULTU).
// Operands are reduced to magnitudes at start, multiplied unsigned over WIDTH
// cycles, then sign-corrected once in FIX before landing in HI/LO.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   result;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a = (mult_sign && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    mag_b = (mult_sign && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
  end

  // Sign fix-up of the unsigned accumulator.
  always_comb begin
    result = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = result[2*WIDTH-1:WIDTH];
        lo_d    = result[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: directed corner cases plus random
// operands, checked against a plain-arithmetic 64-bit product model.
module tb_mult_hilo_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start_mult;
  logic         mult_sign;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fails  = 0;

  logic [2*W-1:0] prev_res;

  mult_hilo_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-precision product in 64-bit integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Called at a negedge after the start edge; waits for done, checking busy,
  // HI/LO hold, latency and result. Operand inputs are scrambled meanwhile.
  task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input int lat, input string tag);
    int          n = 0;
    bit          busy_bad = 0;
    bit          hold_bad = 0;
    logic [63:0] exp;
    exp = ref_prod(a, b, s);
    while (!done && n < 200) begin
      if (busy !== 1'b1) busy_bad = 1;
      if ({hi, lo} !== prev_res) hold_bad = 1;
      op_a      = $urandom;
      op_b      = $urandom;
      mult_sign = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check_eq({tag, " latency"}, 64'(n), 64'(lat));
    check_eq({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    check_eq({tag, " hilo_hold"}, 64'(hold_bad), 64'd0);
    check_eq({tag, " done"}, 64'(done), 64'd1);
    check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check_eq({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check_eq({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    prev_res = exp;
  endtask

  // Must be called at a negedge; issues one start pulse and waits for result.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input string tag);
    op_a       = a;
    op_b       = b;
    mult_sign  = s;
    start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    wait_result(a, b, s, LAT, tag);
  endtask

  logic [31:0] corner [5];

  initial begin
    int          dones;
    logic [31:0] ra, rb;
    logic        rs;

    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;

    rst_n      = 1'b0;
    start_mult = 1'b0;
    mult_sign  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    prev_res   = '0;

    repeat (2) @(negedge clk);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset hi", 64'(hi), 64'd0);
    check_eq("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_and_wait(32'd3, 32'd5, 1'b0, "u3x5");
    @(negedge clk);
    check_eq("u3x5 done_pulse", 64'(done), 64'd0);

    start_and_wait(32'hFFFF_FFFF, 32'd1, 1'b1, "s-1x1");
    @(negedge clk);
    start_and_wait(32'hFFFF_FFFF, 32'd1, 1'b0, "uFFx1");
    @(negedge clk);
    start_and_wait(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "uFFxFF");
    @(negedge clk);
    start_and_wait(32'h8000_0000, 32'h8000_0000, 1'b1, "s80x80");
    @(negedge clk);

    // Request while busy must be ignored.
    op_a = 32'd7; op_b = 32'd6; mult_sign = 1'b0; start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (9) @(negedge clk);
    op_a = 32'd2; op_b = 32'd2; start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    wait_result(32'd7, 32'd6, 1'b0, LAT - 10, "ignored");
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("ignored extra_done", 64'(dones), 64'd0);
    check_eq("ignored lo_hold", 64'(lo), 64'h2A);

    // Back-to-back: second start in the done cycle of the first.
    start_and_wait(32'd4, 32'd4, 1'b0, "b2b_first");
    start_and_wait(32'd9, 32'd9, 1'b0, "b2b_second");
    @(negedge clk);

    // Asynchronous reset mid-CALC.
    op_a = 32'd5; op_b = 32'd7; mult_sign = 1'b0; start_mult = 1'b1;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst done", 64'(done), 64'd0);
    check_eq("midrst hi", 64'(hi), 64'd0);
    check_eq("midrst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = '0;
    @(negedge clk);
    start_and_wait(32'd2, 32'd3, 1'b0, "post_rst");
    @(negedge clk);

    // Random operands, biased toward corner values.
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rs = 1'($urandom);
      start_and_wait(ra, rb, rs, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
